// File: rtl/seg7_capture_if.sv
// Multiplexed 7-segment bus as seen by the capture block: the scanned
// segment/digit-enable lines come in, recovered digit state and pulses go out.
interface seg7_capture_if #(
    parameter int NDIG = 4
);
    logic [6:0]        seg_in;
    logic [NDIG-1:0]   dig_en;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   digit_valid;
    logic              upd;
    logic              err;
    logic              frame_done;

    // master drives the display bus and observes the recovered state
    modport master (
        output seg_in, dig_en,
        input  digits, digit_valid, upd, err, frame_done
    );

    // slave is the capture block itself
    modport slave (
        input  seg_in, dig_en,
        output digits, digit_valid, upd, err, frame_done
    );
endinterface

// File: rtl/seg7_capture.sv
// Recovers per-digit hex values from a time-multiplexed active-high
// 7-segment bus. A pattern must be held for STABLE_CYC consecutive samples
// before it is decoded, which filters scan-transition ghosting. Capture
// produces one-cycle upd/err/frame_done pulses; all outputs are registered.
module seg7_capture #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input logic           clk,
    input logic           rst,
    seg7_capture_if.slave bus
);
    localparam int        SW      = NDIG + 7;
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);
    // Capture fires on the cycle the counter steps onto CNT_MAX.
    localparam logic [7:0] CNT_CAP = 8'(STABLE_CYC - 2);

    // Returns {legal, value}; legal=0 for blank and illegal patterns.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h7E:   decode = 5'h10;
            7'h30:   decode = 5'h11;
            7'h6D:   decode = 5'h12;
            7'h79:   decode = 5'h13;
            7'h33:   decode = 5'h14;
            7'h5B:   decode = 5'h15;
            7'h5F:   decode = 5'h16;
            7'h70:   decode = 5'h17;
            7'h7F:   decode = 5'h18;
            7'h7B:   decode = 5'h19;
            7'h77:   decode = 5'h1A;
            7'h1F:   decode = 5'h1B;
            7'h4E:   decode = 5'h1C;
            7'h3D:   decode = 5'h1D;
            7'h4F:   decode = 5'h1E;
            7'h47:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    logic [SW-1:0]     s_q;
    logic [SW-1:0]     p_q;
    logic [7:0]        cnt;
    logic [4*NDIG-1:0] digits_q;
    logic [NDIG-1:0]   valid_q;
    logic [NDIG-1:0]   seen_q;
    logic              upd_q;
    logic              err_q;
    logic              fd_q;

    logic              capture;
    logic [NDIG-1:0]   cap_en;
    logic [6:0]        cap_seg;
    logic              one_hot;
    logic              multi_hot;
    logic [4:0]        dec;
    logic [NDIG-1:0]   seen_next;

    // Capture qualification and decode of the registered sample
    always_comb begin
        cap_en    = s_q[SW-1:7];
        cap_seg   = s_q[6:0];
        capture   = (s_q == p_q) && (cnt == CNT_CAP);
        one_hot   = (cap_en != '0) && ((cap_en & (cap_en - NDIG'(1))) == '0);
        multi_hot = (cap_en != '0) && !one_hot;
        dec       = decode(cap_seg);
        seen_next = seen_q | cap_en;
    end

    // Input sampling and saturating stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
            p_q <= '0;
            cnt <= '0;
        end else begin
            s_q <= {bus.dig_en, bus.seg_in};
            p_q <= s_q;
            if (s_q != p_q)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 8'd1;
        end
    end

    // Digit state, frame tracking and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= '0;
            valid_q  <= '0;
            seen_q   <= '0;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            err_q <= 1'b0;
            fd_q  <= 1'b0;
            if (capture && multi_hot) begin
                // Ambiguous enable: flag it and leave digit state alone.
                err_q <= 1'b1;
            end else if (capture && one_hot) begin
                upd_q <= 1'b1;
                for (int i = 0; i < NDIG; i++) begin
                    if (cap_en[i]) begin
                        if (dec[4]) begin
                            digits_q[4*i +: 4] <= dec[3:0];
                            valid_q[i]         <= 1'b1;
                        end else begin
                            // Blank or garbage: keep the last value, mark stale.
                            valid_q[i] <= 1'b0;
                            if (cap_seg != 7'h00)
                                err_q <= 1'b1;
                        end
                    end
                end
                if (&seen_next) begin
                    fd_q   <= 1'b1;
                    seen_q <= '0;
                end else begin
                    seen_q <= seen_next;
                end
            end
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.upd         = upd_q;
    assign bus.err         = err_q;
    assign bus.frame_done  = fd_q;
endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: a per-sample reference model predicts
// every capture event (timing and resulting state) into a queue, and a
// negedge monitor pops and compares whenever upd or err pulses.
module tb_seg7_capture;
    localparam int NDIG       = 4;
    localparam int STABLE_CYC = 4;
    localparam int OW         = 4*NDIG + NDIG + 3;
    localparam int EW         = 32 + OW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_capture_if #(.NDIG(NDIG)) bus ();

    seg7_capture #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int              cyc    = 0;
    int              n_vec  = 0;
    int              n_miss = 0;
    logic [EW-1:0]   exp_q[$];

    // reference model state
    logic [NDIG+6:0] m_last;
    int              m_run;
    logic [3:0]      m_dig [NDIG];
    logic [NDIG-1:0] m_valid;
    logic [NDIG-1:0] m_seen;

    task automatic model_reset();
        m_last  = '0;
        m_run   = STABLE_CYC + 1;
        m_valid = '0;
        m_seen  = '0;
        for (int i = 0; i < NDIG; i++) m_dig[i] = 4'h0;
    endtask

    task automatic push_event(input int at, input logic u, input logic e, input logic f);
        logic [4*NDIG-1:0] flat;
        for (int i = 0; i < NDIG; i++) flat[4*i +: 4] = m_dig[i];
        exp_q.push_back({32'(at), flat, m_valid, u, e, f});
    endtask

    task automatic model_capture(input logic [NDIG-1:0] en, input logic [6:0] seg, input int at);
        int   idx;
        int   val;
        logic e;
        logic f;
        if (en == '0) return;
        if ($countones(en) > 1) begin
            push_event(at, 1'b0, 1'b1, 1'b0);
            return;
        end
        idx = 0;
        for (int i = 0; i < NDIG; i++) if (en[i]) idx = i;
        val = -1;
        for (int k = 0; k < 16; k++) if (pat[k] == seg) val = k;
        if (val >= 0) begin
            m_dig[idx]   = 4'(val);
            m_valid[idx] = 1'b1;
            e = 1'b0;
        end else begin
            m_valid[idx] = 1'b0;
            e = (seg != 7'h00);
        end
        m_seen[idx] = 1'b1;
        f = &m_seen;
        if (f) m_seen = '0;
        push_event(at, 1'b1, e, f);
    endtask

    // A pattern is decoded once it has been sampled STABLE_CYC times in a row;
    // the result appears on the following edge.
    task automatic model_sample(input logic [NDIG-1:0] en, input logic [6:0] seg, input int at);
        logic [NDIG+6:0] v;
        v = {en, seg};
        if (v == m_last) begin
            if (m_run <= STABLE_CYC) m_run++;
        end else begin
            m_last = v;
            m_run  = 1;
        end
        if (m_run == STABLE_CYC) model_capture(en, seg, at);
    endtask

    // clock/reset block: every posedge passes through here
    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else     model_sample(bus.dig_en, bus.seg_in, cyc + 1);
    endtask

    task automatic do_reset(input int n);
        logic [OW-1:0] got;
        @(negedge clk);
        rst = 1'b1;
        repeat (n) begin
            step();
            #1;
            got = {bus.digits, bus.digit_valid, bus.upd, bus.err, bus.frame_done};
            n_vec++;
            if (got !== '0) begin
                n_miss++;
                $display("FAIL reset_state: got %h expected %h", got, {OW{1'b0}});
            end
        end
    endtask

    // driver: present a pattern (and release reset) for n clock edges
    task automatic drive(input logic [NDIG-1:0] en, input logic [6:0] seg, input int n);
        @(negedge clk);
        rst        = 1'b0;
        bus.dig_en = en;
        bus.seg_in = seg;
        repeat (n) step();
    endtask

    // monitor: every upd/err pulse must match the next predicted event
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [OW-1:0] got;
        if (bus.upd === 1'b1 || bus.err === 1'b1) begin
            got = {bus.digits, bus.digit_valid, bus.upd, bus.err, bus.frame_done};
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_event: cycle %0d got %h expected no event", cyc, got);
            end else begin
                e = exp_q.pop_front();
                n_vec++;
                if (cyc != int'(e[EW-1 -: 32])) begin
                    n_miss++;
                    $display("FAIL event_timing: got cycle %0d expected cycle %0d", cyc, int'(e[EW-1 -: 32]));
                end
                n_vec++;
                if (got !== e[OW-1:0]) begin
                    n_miss++;
                    $display("FAIL event_outputs: cycle %0d got digits=%h valid=%b upd=%b err=%b fd=%b expected digits=%h valid=%b upd=%b err=%b fd=%b",
                             cyc, got[OW-1 -: 4*NDIG], got[NDIG+2:3], got[2], got[1], got[0],
                             e[OW-1 -: 4*NDIG], e[NDIG+2:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        logic [NDIG-1:0] en;
        logic [6:0]      seg;
        int              r;
        bus.dig_en = 4'b0001;
        bus.seg_in = 7'h7F;
        model_reset();

        // reset with a lit pattern already on the bus, then first capture
        do_reset(3);
        drive(4'b0001, 7'h7F, 8);

        // full scan
        drive(4'b0001, 7'h30, 8);
        drive(4'b0010, 7'h6D, 8);
        drive(4'b0100, 7'h79, 8);
        drive(4'b1000, 7'h33, 8);

        // glitch filter and no re-fire while held
        drive(4'b0001, 7'h5B, 3);
        drive(4'b0001, 7'h5F, 10);
        drive(4'b0001, 7'h5F, 100);

        // illegal then blank pattern
        drive(4'b0010, 7'h01, 8);
        drive(4'b0010, 7'h00, 8);

        // multi-hot enable, then idle enable
        drive(4'b0110, 7'h7E, 8);
        drive(4'b0000, 7'h7E, 8);

        // reset in the middle of a stability window
        drive(4'b1000, 7'h4F, 2);
        do_reset(1);
        drive(4'b1000, 7'h4F, 8);
        drive(4'b0001, 7'h30, 8);
        drive(4'b0010, 7'h6D, 8);
        drive(4'b0100, 7'h79, 8);

        // randomized scan traffic
        for (int s = 0; s < 300; s++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                en = 4'b0001 << $urandom_range(0, NDIG - 1);
            end else if (r == 7) begin
                en = '0;
            end else begin
                en = 4'($urandom_range(0, 15));
                while ($countones(en) < 2) en = 4'($urandom_range(0, 15));
            end
            r = $urandom_range(0, 9);
            if (r < 7)       seg = pat[$urandom_range(0, 15)];
            else if (r == 7) seg = 7'h00;
            else             seg = 7'($urandom_range(0, 127));
            drive(en, seg, $urandom_range(1, 8));
        end

        // flush and make sure nothing predicted went missing
        drive(4'b0000, 7'h00, 12);
        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL missing_events: got %0d unserved expected events, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Receive-side counterpart of the team's hex/BCD-to-7-segment encoder.
- Samples a time-multiplexed, active-high 7-segment bus (segment lines plus one-hot digit enables) and recovers the 4-bit value shown on each digit.
- Filters scan transitions, flags illegal patterns, and signals when a full scan frame has been recovered.
- Used in display loopback checking and in the front panel readback path.

Parameters:
- NDIG, 4, number of multiplexed digits (1..8).
- STABLE_CYC, 4, consecutive identical samples required before a pattern is decoded (2..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- seg_in  in  7  segment lines; bit6=a, bit5=b … bit0=g; 1=lit.
- dig_en  in  NDIG  digit enables, active-high, one-hot while scanning.
- digits  out  4*NDIG  recovered values; digit i at bits [4i+3:4i].
- digit_valid  out  NDIG  1 = digit i holds a value decoded from a legal lit pattern.
- upd  out  1  one-cycle pulse on each capture (legal, blank or illegal).
- err  out  1  one-cycle pulse on illegal segment pattern or non-one-hot nonzero dig_en.
- frame_done  out  1  one-cycle pulse when every digit has been captured since the last pulse.

Behaviour:
- Reset: digits=0, digit_valid=0, upd=0, err=0, frame_done=0. Input register, previous-sample register, stability counter and seen-mask all cleared.
- Reset mid-window discards the partial stability count; no capture fires from pre-reset samples.
- Input stage: {dig_en, seg_in} is registered every cycle into s_q.
- Stability counter cnt (8-bit, saturating):
  - cnt=0 when s_q differs from the previous s_q.
  - Otherwise cnt increments, saturating at STABLE_CYC-1.
- Capture event: fires on the single cycle cnt reaches STABLE_CYC-1. It does not re-fire while the pattern is held; a new capture needs a change and then a fresh stable window.
- Latency: outputs update STABLE_CYC+1 clock edges after the inputs settle.
- dig_en handling at capture:
  - dig_en=0: no action; no upd, no err.
  - More than one bit set: err pulse only; no digit state changes.
  - Exactly one bit i set: decode seg_in per the rules below.
- Decode (hex, a..g MSB-first): 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9, 77→A, 1F→B, 4E→C, 3D→D, 4F→E, 47→F.
  - Legal pattern: digits[i]=value, digit_valid[i]=1, upd=1.
  - Pattern 00 (blank): digits[i] unchanged, digit_valid[i]=0, upd=1.
  - Any other pattern: digits[i] unchanged, digit_valid[i]=0, upd=1, err=1.
- Frame tracking:
  - Bit i of the seen-mask is set on any one-hot capture of digit i.
  - When the mask, including the current capture, becomes all ones: frame_done pulses with that capture's upd, and the mask clears in the same cycle.
  - Repeated captures of one digit do not advance the frame.
- All outputs are registered. Pulses last exactly one cycle. No combinational path from inputs to outputs.

Test Plan:
- Reset/idle: assert rst 3 cycles with seg_in=7F, dig_en=0001, then release → all outputs 0 during reset. First upd arrives exactly STABLE_CYC+1 edges after release (5 with defaults): digits[3:0]=8, digit_valid=0001.
- Full scan: hold dig_en=0001/seg 30, 0010/seg 6D, 0100/seg 79, 1000/seg 33, 8 cycles each → digits=16'h4321, digit_valid=1111, four upd pulses, frame_done coincident with the 4th upd, err never set.
- Glitch filter: hold 0001/5B for 3 cycles, then switch to 0001/5F for 10 cycles → exactly one upd, digits[3:0]=6. Holding 5F for 100 more cycles → no further upd.
- Illegal/blank: after the full scan, present 0010/seg 01 stable → err pulse, digit_valid[1]=0, digits[7:4] stays 2. Then 0010/seg 00 → upd, no err, digit_valid[1]=0.
- Bad enable: dig_en=0110, seg 7E, stable → err pulse, no upd, digits and digit_valid unchanged. dig_en=0000 stable → no pulses.
- Reset mid-window: pattern 1000/4F held 2 cycles, rst for 1 cycle, pattern still held → no capture until STABLE_CYC+1 edges after rst release; then digits[15:12]=E, seen-mask restarted (frame_done only after all 4 digits are recaptured).
